lcd_write_seq: RTL and testbench
================================

# lcd_write_seq

Byte-write sequencer for the dual-controller 128x64 graphic LCD (two KS0108-class halves selected by CS1/CS2). Drawing logic upstream presents one (page, column, data) write at a time on a valid/ready handshake. The block runs the panel power-up command sequence, then turns each request into three timed bus writes: set page, set column, write data. It owns the LCD_* pins and runs on the same divided LCD clock as the drawing logic.

## Interface

- T_SU, 1: cycles in the setup phase (EN low, bus valid); must be ≥1
- T_EN, 2: cycles with LCD_en high; must be ≥1
- T_HOLD, 1: cycles in the hold phase (EN low, bus held); must be ≥1
- RST_CYC, 4: cycles LCD_rstn stays low after rst_n releases; must be ≥1
- clk  in  1  LCD sequencing clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  write request present
- req_page  in  3  page (8-pixel row band) 0..7
- req_col  in  7  column 0..127; bit 6 selects the half
- req_data  in  8  pixel byte, LSB = top pixel
- req_ready  out  1  block can accept a request this cycle
- init_done  out  1  power-up sequence complete; stays 1 until reset
- LCD_data  out  8  LCD data bus
- LCD_en  out  1  LCD enable strobe; the panel latches on the falling edge
- LCD_rw  out  1  tied 0 (write-only)
- LCD_rstn  out  1  panel reset, active low
- LCD_cs1  out  1  left-half select, active high
- LCD_cs2  out  1  right-half select, active high
- LCD_di  out  1  0 = command, 1 = display data

## Operation

- All outputs are registered. Reset values: LCD_data=0x00, LCD_en=0, LCD_rw=0, LCD_rstn=0, LCD_cs1=0, LCD_cs2=0, LCD_di=0, req_ready=0, init_done=0.
- States: RST_WAIT, INIT_ON, INIT_LINE, IDLE, PAGE, COL, DATA.
- Bus-transaction states (INIT_ON..DATA except IDLE) each run three phases: SU for T_SU cycles, EN for T_EN cycles, HOLD for T_HOLD cycles. T_TOT = T_SU+T_EN+T_HOLD.
- LCD_data, LCD_di and the CS lines are constant across all three phases of a transaction. LCD_en=1 only in the EN phase.
- RST_WAIT: LCD_rstn=0 for RST_CYC cycles, then LCD_rstn=1 and go to INIT_ON.
- INIT_ON: LCD_data=0x3F (display on), di=0, cs1=cs2=1.
- INIT_LINE: LCD_data=0xC0 (start line 0), di=0, cs1=cs2=1. At the end set init_done=1 and go to IDLE.
- IDLE: req_ready=1, cs1=cs2=0, LCD_en=0. LCD_data and LCD_di hold their last values.
- Acceptance is req_valid & req_ready at a clock edge. At that edge: latch page, col and data; set req_ready=0; go to PAGE.
- Half select from the latched column: col[6]=0 gives cs1=1, cs2=0. col[6]=1 gives cs1=0, cs2=1.
- PAGE: data=0xB8|page, di=0.
- COL: data=0x40|col[5:0], di=0.
- DATA: data=latched byte, di=1.
- After DATA completes, go to IDLE. No address caching: every request issues all three transactions.
- Request inputs are sampled only at acceptance. Changes to them while req_ready=0 are ignored, and requests before init_done are not accepted.
- Reset asserted mid-operation clears all state and outputs at once (LCD_en drops asynchronously), then the full init sequence reruns.

## Timing

- Relative cycles are counted after rst_n rises. Default parameters give:
  - LCD_rstn=0 for cycles 1..4.
  - INIT_ON occupies cycles 5..8, with EN high in 6..7.
  - INIT_LINE occupies cycles 9..12.
  - req_ready=1 and init_done=1 from cycle 13.
- Relative cycles are counted after the acceptance edge. In general:
  - PAGE occupies cycles 1..T_TOT, COL the next T_TOT cycles, DATA the next T_TOT.
  - req_ready=1 again in cycle 3*T_TOT+1, which is 13 with defaults.
- Default EN-high cycles: PAGE 2..3, COL 6..7, DATA 10..11.
- Back-to-back: with req_valid held high, the next request is accepted at the edge ending cycle 13. The sustained rate is one write per 3*T_TOT+1 cycles.
- LCD_en never rises in the same cycle that LCD_data, LCD_di or a CS line changes.

## Test plan

- Reset release, no requests: LCD_rstn low 4 cycles, then 0x3F and 0xC0 strobes with cs1=cs2=1 and di=0. EN high 2 cycles each. init_done=1 and req_ready=1 at cycle 13.
- Write page=2, col=5, data=0xA5: strobes 0xBA, 0x45 (di=0), then 0xA5 (di=1). cs1=1, cs2=0 throughout. req_ready returns 13 cycles after acceptance.
- Write page=0, col=64, data=0xFF: cs2=1, cs1=0. Strobes 0xB8, 0x40, 0xFF.
- Write page=7, col=127, data=0x00: strobes 0xBF, 0x7F, 0x00 with cs2=1.
- req_valid held high for 3 requests with the inputs changed mid-transaction: exactly 3 acceptances, 13 cycles apart. Each uses only the values sampled at its own acceptance.
- rst_n pulsed low during the COL EN phase: LCD_en=0 and LCD_rstn=0 immediately, all outputs at reset values, then the full init sequence repeats. No DATA strobe is issued for the aborted request.

Source files
------------

// File: rtl/lcd_write_seq.sv
// ============================================================================
// Module   : lcd_write_seq
// Brief    : Power-up and page/column/data write sequencer for a dual-half
//            KS0108-class 128x64 graphic LCD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_write_seq #(
    parameter int T_SU    = 1,
    parameter int T_EN    = 2,
    parameter int T_HOLD  = 1,
    parameter int RST_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_page,
    input  logic [6:0] req_col,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] LCD_data,
    output logic       LCD_en,
    output logic       LCD_rw,
    output logic       LCD_rstn,
    output logic       LCD_cs1,
    output logic       LCD_cs2,
    output logic       LCD_di
);

    localparam int c_MAX_A = (T_SU > T_EN) ? T_SU : T_EN;
    localparam int c_MAX_B = (c_MAX_A > T_HOLD) ? c_MAX_A : T_HOLD;
    localparam int c_MAX   = (c_MAX_B > RST_CYC) ? c_MAX_B : RST_CYC;
    localparam int c_CW    = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CW-1:0] c_SU_LAST   = c_CW'(T_SU - 1);
    localparam logic [c_CW-1:0] c_EN_LAST   = c_CW'(T_EN - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(T_HOLD - 1);
    localparam logic [c_CW-1:0] c_RST_LAST  = c_CW'(RST_CYC - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    localparam logic [2:0] S_RST_WAIT  = 3'd0;
    localparam logic [2:0] S_INIT_ON   = 3'd1;
    localparam logic [2:0] S_INIT_LINE = 3'd2;
    localparam logic [2:0] S_IDLE      = 3'd3;
    localparam logic [2:0] S_PAGE      = 3'd4;
    localparam logic [2:0] S_COL       = 3'd5;
    localparam logic [2:0] S_DATA      = 3'd6;

    localparam logic [1:0] PH_SU   = 2'd0;
    localparam logic [1:0] PH_EN   = 2'd1;
    localparam logic [1:0] PH_HOLD = 2'd2;

    logic [2:0]      r_state;
    logic [1:0]      r_ph;
    logic [c_CW-1:0] r_cnt;
    logic [5:0]      r_col;
    logic [7:0]      r_byte;
    logic            r_ready;
    logic            r_init_done;
    logic [7:0]      r_data;
    logic            r_en;
    logic            r_rw;
    logic            r_rstn;
    logic            r_cs1;
    logic            r_cs2;
    logic            r_di;

    // Each transaction loads bus/di/cs on entry to SU, so those lines are
    // already stable for at least T_SU cycles before EN rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RST_WAIT;
            r_ph        <= PH_SU;
            r_cnt       <= '0;
            r_col       <= '0;
            r_byte      <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_rw        <= 1'b0;
            r_rstn      <= 1'b0;
            r_cs1       <= 1'b0;
            r_cs2       <= 1'b0;
            r_di        <= 1'b0;
        end else begin
            r_rw <= 1'b0;
            case (r_state)
                S_RST_WAIT: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_rstn  <= 1'b1;
                        r_state <= S_INIT_ON;
                        r_data  <= 8'h3F;
                        r_di    <= 1'b0;
                        r_cs1   <= 1'b1;
                        r_cs2   <= 1'b1;
                        r_ph    <= PH_SU;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_col   <= req_col[5:0];
                        r_byte  <= req_data;
                        r_ready <= 1'b0;
                        r_state <= S_PAGE;
                        r_data  <= {5'b10111, req_page};
                        r_di    <= 1'b0;
                        r_cs1   <= ~req_col[6];
                        r_cs2   <= req_col[6];
                        r_ph    <= PH_SU;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    case (r_ph)
                        PH_SU: begin
                            if (r_cnt == c_SU_LAST) begin
                                r_ph  <= PH_EN;
                                r_en  <= 1'b1;
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                        PH_EN: begin
                            if (r_cnt == c_EN_LAST) begin
                                r_ph  <= PH_HOLD;
                                r_en  <= 1'b0;
                                r_cnt <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                        default: begin
                            if (r_cnt == c_HOLD_LAST) begin
                                r_cnt <= '0;
                                r_ph  <= PH_SU;
                                case (r_state)
                                    S_INIT_ON: begin
                                        r_state <= S_INIT_LINE;
                                        r_data  <= 8'hC0;
                                    end
                                    S_PAGE: begin
                                        r_state <= S_COL;
                                        r_data  <= {2'b01, r_col};
                                    end
                                    S_COL: begin
                                        r_state <= S_DATA;
                                        r_data  <= r_byte;
                                        r_di    <= 1'b1;
                                    end
                                    default: begin
                                        // INIT_LINE or DATA done: bus and di hold, halves deselected
                                        r_state     <= S_IDLE;
                                        r_ready     <= 1'b1;
                                        r_init_done <= 1'b1;
                                        r_cs1       <= 1'b0;
                                        r_cs2       <= 1'b0;
                                    end
                                endcase
                            end else begin
                                r_cnt <= r_cnt + c_CNT_ONE;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_init_done;
    assign LCD_data  = r_data;
    assign LCD_en    = r_en;
    assign LCD_rw    = r_rw;
    assign LCD_rstn  = r_rstn;
    assign LCD_cs1   = r_cs1;
    assign LCD_cs2   = r_cs2;
    assign LCD_di    = r_di;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_seq.sv
// ============================================================================
// Module   : tb_lcd_write_seq
// Brief    : Scoreboard bench for lcd_write_seq: expected strobes queued by
//            stimulus, checked by a monitor on each LCD_en falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_write_seq;

    localparam int T_EN = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_page;
    logic [6:0] req_col;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic [7:0] LCD_data;
    logic       LCD_en;
    logic       LCD_rw;
    logic       LCD_rstn;
    logic       LCD_cs1;
    logic       LCD_cs2;
    logic       LCD_di;

    lcd_write_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_page  (req_page),
        .req_col   (req_col),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .LCD_data  (LCD_data),
        .LCD_en    (LCD_en),
        .LCD_rw    (LCD_rw),
        .LCD_rstn  (LCD_rstn),
        .LCD_cs1   (LCD_cs1),
        .LCD_cs2   (LCD_cs2),
        .LCD_di    (LCD_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus word {rw, cs1, cs2, di, data}
    logic [11:0] exp_q[$];
    int          acc_q[$];
    int          cyc = 0;

    task automatic push_exp(input logic [7:0] d, input logic di, input logic cs1, input logic cs2);
        exp_q.push_back({1'b0, cs1, cs2, di, d});
    endtask

    wire [11:0] w_bus = {LCD_rw, LCD_cs1, LCD_cs2, LCD_di, LCD_data};

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    // Strobe monitor
    logic        m_prev_en  = 1'b0;
    logic [11:0] m_prev_bus = '0;
    logic [11:0] m_snap     = '0;
    int          m_len      = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_en  = 1'b0;
            m_len      = 0;
            m_prev_bus = w_bus;
        end else begin
            if (LCD_en && !m_prev_en) begin
                chk("bus_stable_at_en_rise", w_bus, m_prev_bus);
                m_snap = w_bus;
                m_len  = 1;
            end else if (LCD_en) begin
                chk("bus_stable_in_en", w_bus, m_snap);
                m_len++;
            end else if (m_prev_en) begin
                chk("bus_stable_in_hold", w_bus, m_snap);
                chk("en_width", m_len, T_EN);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", m_snap, 12'hFFF);
                end else begin
                    chk("strobe_bus", m_snap, exp_q.pop_front());
                end
            end
            m_prev_en  = LCD_en;
            m_prev_bus = w_bus;
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, LCD_data, 8'h00);
        chk({tag, "_en"}, LCD_en, 1'b0);
        chk({tag, "_rw"}, LCD_rw, 1'b0);
        chk({tag, "_rstn"}, LCD_rstn, 1'b0);
        chk({tag, "_cs"}, {LCD_cs1, LCD_cs2}, 2'b00);
        chk({tag, "_di"}, LCD_di, 1'b0);
        chk({tag, "_ready"}, req_ready, 1'b0);
        chk({tag, "_init_done"}, init_done, 1'b0);
    endtask

    // Called at a negedge while rst_n is low; releases reset and checks init timing.
    task automatic run_init;
        push_exp(8'h3F, 1'b0, 1'b1, 1'b1);
        push_exp(8'hC0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        for (int k = 2; k <= 13; k++) begin
            tick();
            chk("init_rstn", LCD_rstn, (k >= 5));
            chk("init_en", LCD_en, (k == 6 || k == 7 || k == 10 || k == 11));
            chk("init_ready", req_ready, (k >= 13));
            chk("init_done", init_done, (k >= 13));
        end
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        chk("wait_ready_timeout", req_ready, 1'b1);
    endtask

    task automatic do_write(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d,
                            input logic [7:0] e_page, input logic [7:0] e_col);
        wait_ready();
        req_page  = p;
        req_col   = c;
        req_data  = d;
        req_valid = 1'b1;
        push_exp(e_page, 1'b0, ~c[6], c[6]);
        push_exp(e_col, 1'b0, ~c[6], c[6]);
        push_exp(d, 1'b1, ~c[6], c[6]);
        tick();
        req_valid = 1'b0;
        req_page  = ~p;
        req_col   = ~c;
        req_data  = ~d;
        for (int k = 1; k <= 13; k++) begin
            chk("wr_en", LCD_en, (k == 2 || k == 3 || k == 6 || k == 7 || k == 10 || k == 11));
            chk("wr_ready", req_ready, (k == 13));
            if (k < 13) tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_page  = '0;
        req_col   = '0;
        req_data  = '0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        run_init();

        do_write(3'd2, 7'd5, 8'hA5, 8'hBA, 8'h45);
        do_write(3'd0, 7'd64, 8'hFF, 8'hB8, 8'h40);
        do_write(3'd7, 7'd127, 8'h00, 8'hBF, 8'h7F);

        // Back-to-back with inputs disturbed mid-transaction
        wait_ready();
        acc_q.delete();
        req_valid = 1'b1;
        req_page  = 3'd1; req_col = 7'd3; req_data = 8'h12;
        push_exp(8'hB9, 1'b0, 1'b1, 1'b0);
        push_exp(8'h43, 1'b0, 1'b1, 1'b0);
        push_exp(8'h12, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) req_valid = 1'b0;
            req_page = 3'd5; req_col = 7'd99; req_data = 8'hEE;
            repeat (6) tick();
            if (i == 0) begin
                req_page = 3'd4; req_col = 7'd70; req_data = 8'h34;
                push_exp(8'hBC, 1'b0, 1'b0, 1'b1);
                push_exp(8'h46, 1'b0, 1'b0, 1'b1);
                push_exp(8'h34, 1'b1, 1'b0, 1'b1);
            end else if (i == 1) begin
                req_page = 3'd6; req_col = 7'd33; req_data = 8'hC3;
                push_exp(8'hBE, 1'b0, 1'b1, 1'b0);
                push_exp(8'h61, 1'b0, 1'b1, 1'b0);
                push_exp(8'hC3, 1'b1, 1'b1, 1'b0);
            end
            repeat (6) tick();
        end
        repeat (3) tick();
        chk("b2b_accept_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("b2b_spacing_1", acc_q[1] - acc_q[0], 13);
            chk("b2b_spacing_2", acc_q[2] - acc_q[1], 13);
        end

        // Reset during the COL EN phase
        wait_ready();
        req_page = 3'd3; req_col = 7'd10; req_data = 8'h55; req_valid = 1'b1;
        push_exp(8'hBB, 1'b0, 1'b1, 1'b0);
        push_exp(8'h4A, 1'b0, 1'b1, 1'b0);
        push_exp(8'h55, 1'b1, 1'b1, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        chk("abort_col_en_high", LCD_en, 1'b1);
        chk("abort_pending", exp_q.size(), 2);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        exp_q.delete();
        repeat (2) tick();
        chk_reset_outputs("abort_held");
        run_init();
        do_write(3'd5, 7'd100, 8'h99, 8'hBD, 8'h64);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
